// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, instruction-memory address, and the IF/ID register.
// Optional macro BRANCH_DELAY_SLOT_EN keeps the fetched delay-slot word on a redirect instead of a bubble.
module fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    output logic [31:0] instrMemAddr,
    input  logic [31:0] instrMemData,
    input  logic        jump,
    input  logic        beq,
    input  logic        bne,
    input  logic        zero,
    input  logic [31:0] idImm,
    output logic [31:0] pc,
    output logic [31:0] ifidInstr,
    output logic [31:0] ifidPcPlus4,
    output logic        ifidValid,
    output logic [5:0]  opCode
);

    logic [31:0] pcPlus4;
    logic [31:0] brTgt;
    logic [31:0] jTgt;
    logic [31:0] redirTgt;
    logic        taken;
    logic        redir;
    logic        unusedImmTop;

    // The shifted immediate drops the top two bits; a valid word offset never needs them.
    assign unusedImmTop = ^idImm[31:30];

    assign pcPlus4  = pc + 32'd4;
    assign brTgt    = ifidPcPlus4 + {idImm[29:0], 2'b00};
    assign jTgt     = {ifidPcPlus4[31:28], ifidInstr[25:0], 2'b00};
    assign taken    = (beq & zero) | (bne & ~zero);
    // A bubble in IF/ID must never steer the PC, whatever Control decodes from it.
    assign redir    = ifidValid & (jump | taken);
    assign redirTgt = jump ? jTgt : brTgt;

    assign instrMemAddr = pc;
    assign opCode       = ifidInstr[31:26];

    // IF -> ID boundary
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= {PC_RESET[31:2], 2'b00};
            ifidInstr   <= 32'h0;
            ifidPcPlus4 <= 32'h0;
            ifidValid   <= 1'b0;
        end else if (stall) begin
            pc          <= pc;
            ifidInstr   <= ifidInstr;
            ifidPcPlus4 <= ifidPcPlus4;
            ifidValid   <= ifidValid;
        end else if (redir) begin
            pc          <= redirTgt;
`ifdef BRANCH_DELAY_SLOT_EN
            ifidInstr   <= instrMemData;
            ifidPcPlus4 <= pcPlus4;
            ifidValid   <= 1'b1;
`else
            ifidInstr   <= 32'h0;
            ifidPcPlus4 <= ifidPcPlus4;
            ifidValid   <= 1'b0;
`endif
        end else begin
            pc          <= pcPlus4;
            ifidInstr   <= instrMemData;
            ifidPcPlus4 <= pcPlus4;
            ifidValid   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, free-run, branches, jumps, stalls and PC wrap.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [31:0] instrMemAddr;
    logic [31:0] instrMemData;
    logic        jump;
    logic        beq;
    logic        bne;
    logic        zero;
    logic [31:0] idImm;
    logic [31:0] pc;
    logic [31:0] ifidInstr;
    logic [31:0] ifidPcPlus4;
    logic        ifidValid;
    logic [5:0]  opCode;

    logic [31:0] memArr [0:63];
    int          testsRun;
    int          testsFailed;

    fetch_stage #(.PC_RESET(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .instrMemAddr (instrMemAddr),
        .instrMemData (instrMemData),
        .jump         (jump),
        .beq          (beq),
        .bne          (bne),
        .zero         (zero),
        .idImm        (idImm),
        .pc           (pc),
        .ifidInstr    (ifidInstr),
        .ifidPcPlus4  (ifidPcPlus4),
        .ifidValid    (ifidValid),
        .opCode       (opCode)
    );

    // Word-addressed memory that aliases every 256 bytes.
    assign instrMemData = memArr[instrMemAddr[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearCtl();
        jump  = 1'b0;
        beq   = 1'b0;
        bne   = 1'b0;
        zero  = 1'b0;
        idImm = 32'h0;
        stall = 1'b0;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        clearCtl();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        for (int i = 0; i < 64; i++) memArr[i] = 32'h2000_0000 + i;
        memArr[0] = 32'h2008_0005;
        memArr[3] = 32'h0800_0100;
        rst_n = 1'b0;
        clearCtl();

        // 1. reset held for three cycles, then release
        repeat (3) step();
        checkVal("rst_pc", pc, 32'h0);
        checkVal("rst_valid", {31'h0, ifidValid}, 32'h0);
        checkVal("rst_instr", ifidInstr, 32'h0);
        checkVal("rst_pcp4", ifidPcPlus4, 32'h0);
        rst_n = 1'b1;
        step();
        checkVal("rel_instr", ifidInstr, 32'h2008_0005);
        checkVal("rel_pcp4", ifidPcPlus4, 32'h4);
        checkVal("rel_pc", pc, 32'h4);
        checkVal("rel_valid", {31'h0, ifidValid}, 32'h1);
        checkVal("rel_opcode", {26'h0, opCode}, 32'h8);
        checkVal("rel_addr", instrMemAddr, 32'h4);

        // 2. free run
        step();
        checkVal("run_pc8", pc, 32'h8);
        checkVal("run_pcp4_8", ifidPcPlus4, 32'h8);
        step();
        checkVal("run_pc12", pc, 32'hC);
        checkVal("run_pcp4_12", ifidPcPlus4, 32'hC);
        checkVal("run_instr", ifidInstr, 32'h2000_0002);

        // 3. taken beq: 12 + 3*4 = 24
        beq = 1'b1; zero = 1'b1; idImm = 32'd3;
        step();
        checkVal("beq_pc", pc, 32'd24);
`ifdef BRANCH_DELAY_SLOT_EN
        checkVal("beq_slot_instr", ifidInstr, 32'h0800_0100);
        checkVal("beq_slot_valid", {31'h0, ifidValid}, 32'h1);
`else
        checkVal("beq_bubble_instr", ifidInstr, 32'h0);
        checkVal("beq_bubble_valid", {31'h0, ifidValid}, 32'h0);
`endif
        clearCtl();
        step();
        checkVal("post_beq_pc", pc, 32'd28);
        checkVal("post_beq_instr", ifidInstr, 32'h2000_0006);
        checkVal("post_beq_pcp4", ifidPcPlus4, 32'd28);

        // 4. bne with zero=1 falls through
        bne = 1'b1; zero = 1'b1; idImm = 32'd5;
        step();
        checkVal("bne_nt_pc", pc, 32'd32);
        doReset();
        step(); step(); step();
        checkVal("bne_setup_pcp4", ifidPcPlus4, 32'hC);
        bne = 1'b1; zero = 1'b0; idImm = 32'hFFFF_FFFE;
        step();
        checkVal("bne_t_pc", pc, 32'h4);

        // 5. branch to 0x4000_000C, fetch the j there, then take it
        doReset();
        step();
        beq = 1'b1; zero = 1'b1; idImm = 32'h1000_0002;
        step();
        checkVal("far_pc", pc, 32'h4000_000C);
        clearCtl();
        step();
        checkVal("j_setup_pcp4", ifidPcPlus4, 32'h4000_0010);
        checkVal("j_setup_instr", ifidInstr, 32'h0800_0100);
        checkVal("j_opcode", {26'h0, opCode}, 32'h2);
        jump = 1'b1;
        step();
        checkVal("jump_pc", pc, 32'h4000_0400);
        // redirect while IF/ID is empty after reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        jump = 1'b1; beq = 1'b1; zero = 1'b1; idImm = 32'd100;
        step();
        checkVal("inv_redir_pc", pc, 32'h4);

        // 6. stall holds a taken beq, then it resolves
        doReset();
        step(); step();
        beq = 1'b1; zero = 1'b1; idImm = 32'd2; stall = 1'b1;
        step(); step();
        checkVal("stall_pc", pc, 32'h8);
        checkVal("stall_pcp4", ifidPcPlus4, 32'h8);
        checkVal("stall_instr", ifidInstr, 32'h2000_0001);
        checkVal("stall_valid", {31'h0, ifidValid}, 32'h1);
        stall = 1'b0;
        step();
        checkVal("unstall_pc", pc, 32'd16);

        // PC wrap: 4 - 8 = 0xFFFF_FFFC, then +4 = 0
        doReset();
        step();
        beq = 1'b1; zero = 1'b1; idImm = 32'hFFFF_FFFE;
        step();
        checkVal("wrap_top_pc", pc, 32'hFFFF_FFFC);
        clearCtl();
        step();
        checkVal("wrap_pc", pc, 32'h0);
        checkVal("wrap_pcp4", ifidPcPlus4, 32'h0);
        checkVal("wrap_instr", ifidInstr, 32'h2000_003F);
        step();
        checkVal("pre_rst_pc", pc, 32'h4);
        stall = 1'b1; rst_n = 1'b0;
        step();
        checkVal("stall_rst_pc", pc, 32'h0);
        checkVal("stall_rst_valid", {31'h0, ifidValid}, 32'h0);
        checkVal("stall_rst_instr", ifidInstr, 32'h0);
        checkVal("stall_rst_pcp4", ifidPcPlus4, 32'h0);
        stall = 1'b0; rst_n = 1'b1;
        step();
        checkVal("resume_pc", pc, 32'h4);
        checkVal("resume_instr", ifidInstr, 32'h2008_0005);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
